wb_fetch: RTL and testbench

- Instruction-fetch front end and Wishbone classic master that sits directly upstream of the boot ROM and other read slaves.
- Walks a sequential word-aligned PC, issues single-word reads, and buffers returned words in a small prefetch FIFO.
- Presents an instruction stream (valid/ready) to the CPU decode stage.
- Supports PC redirect (branch/trap) with flush of stale data.

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/wb_fetch_if.sv | 28 ++
 rtl/fetch_fifo.sv | 71 +++++++
 rtl/wb_fetch.sv | 160 ++++++++++++++++
 tb/tb_wb_fetch.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_pkg;

  // Fetch sequencer states; HALT is only entered when FETCH_ERR_HALT_EN is built in.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2,
    HALT = 2'd3
  } fetch_state_e;

  // Byte distance between consecutive instruction words.
  localparam int PC_STEP = 4;

  // PC field width of a FIFO entry; covers address widths up to 32 bits.
  localparam int PC_W = 32;

  // One prefetched instruction: data word, its address, bus-error flag.
  typedef struct packed {
    logic [31:0]     insn;
    logic [PC_W-1:0] pc;
    logic            err;
  } fetch_entry_t;

endpackage

// File: rtl/wb_fetch_if.sv
// Wishbone classic read/write bus bundle between the fetch master and its slaves.
// Latency: n/a (wiring only).
// Backpressure: the slave stalls the master by withholding wb_ack/wb_err.
interface wb_fetch_if #(
  parameter int ADDR_WIDTH = 32
) ();

  logic                  wb_cyc;
  logic                  wb_stb;
  logic                  wb_we;
  logic [ADDR_WIDTH-1:0] wb_adr;
  logic [31:0]           wb_mosi;
  logic [3:0]            wb_sel;
  logic [31:0]           wb_miso;
  logic                  wb_ack;
  logic                  wb_err;

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_adr, wb_mosi, wb_sel,
    input  wb_miso, wb_ack, wb_err
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_adr, wb_mosi, wb_sel,
    output wb_miso, wb_ack, wb_err
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with flush, occupancy count and full/empty flags.
// Latency: a pushed entry is visible at the head the cycle after the push edge.
// Backpressure: push is ignored when full unless a pop happens in the same cycle.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 65
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_push_dat,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_pop_dat,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_pop_dat = r_mem[r_rd_ptr];

  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // Storage write; contents need no reset because occupancy gates visibility.
  always_ff @(posedge sys_clk) begin
    if (w_do_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  // Pointer and occupancy tracking; flush empties the FIFO on the edge.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/wb_fetch.sv
// Instruction fetch: sequential Wishbone single-word reads into a prefetch FIFO feeding decode.
// Latency: one word per 3 cycles peak (IDLE->REQ->GAP) against a slave acking in the REQ cycle.
// Backpressure: no request is issued while the FIFO has no free slot; fetch_ready pops the head.
// Build option FETCH_ERR_HALT_EN: stop fetching after a bus error until the next redirect.
module wb_fetch
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    DEPTH      = 2
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  wb_fetch_if.master            wb,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  fetch_valid,
  input  logic                  fetch_ready,
  output logic [31:0]           fetch_insn,
  output logic [ADDR_WIDTH-1:0] fetch_pc,
  output logic                  fetch_err
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e          r_state;
  fetch_state_e          w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_adr;
  logic                  r_discard;

  logic                  w_cyc;
  logic                  w_done;
  logic                  w_inflight;
  logic                  w_issue;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [CW-1:0]         w_count;
  logic [CW-1:0]         w_free;
  logic [ADDR_WIDTH-1:0] w_redir_pc;
  fetch_entry_t          w_push_ent;
  fetch_entry_t          w_head;

  // Read-only master: write controls are tied off.
  assign wb.wb_cyc  = w_cyc;
  assign wb.wb_stb  = w_cyc;
  assign wb.wb_we   = 1'b0;
  assign wb.wb_adr  = r_adr;
  assign wb.wb_mosi = 32'h0;
  assign wb.wb_sel  = 4'hF;

  assign w_redir_pc = redirect_pc & ~ADDR_WIDTH'(3);
  assign w_done     = (r_state == REQ) & (wb.wb_ack | wb.wb_err);
  assign w_inflight = (r_state == REQ);
  assign w_free     = CW'(DEPTH) - w_count;

  // Only start a read when the result is guaranteed a slot; redirects hold off issue for a cycle.
  assign w_issue = (r_state == IDLE) & ~redirect_valid & (w_free > CW'(w_inflight));

  // A redirect flushes the FIFO, so neither a coinciding pop nor a coinciding push survives it.
  assign w_pop  = fetch_valid & fetch_ready & ~redirect_valid;
  assign w_push = w_done & ~r_discard & ~redirect_valid & (~w_full | w_pop);

  assign w_push_ent.insn = wb.wb_err ? 32'h0 : wb.wb_miso;
  assign w_push_ent.pc   = PC_W'(r_adr);
  assign w_push_ent.err  = wb.wb_err;

  assign fetch_valid = ~w_empty;
  assign fetch_insn  = w_head.insn;
  assign fetch_pc    = ADDR_WIDTH'(w_head.pc);
  assign fetch_err   = w_head.err;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .i_flush    (redirect_valid),
    .i_push     (w_push),
    .i_push_dat (w_push_ent),
    .i_pop      (w_pop),
    .o_pop_dat  (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (w_count)
  );

  // State register; reset drops cyc/stb immediately since they decode from the state.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and bus strobe decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cyc       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_issue) begin
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        w_cyc = 1'b1;
        if (w_done) begin
          w_state_nxt = GAP;
`ifdef FETCH_ERR_HALT_EN
          if (w_push && wb.wb_err) begin
            w_state_nxt = HALT;
          end
`endif
        end
      end
      GAP: begin
        w_state_nxt = IDLE;
      end
`ifdef FETCH_ERR_HALT_EN
      HALT: begin
        if (redirect_valid) begin
          w_state_nxt = IDLE;
        end
      end
`endif
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // PC, bus address and discard tracking; a redirect always wins over sequential advance.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_pc      <= RESET_PC;
      r_adr     <= '0;
      r_discard <= 1'b0;
    end else begin
      if (w_issue) begin
        r_adr <= r_pc;
      end
      if (redirect_valid) begin
        r_pc      <= w_redir_pc;
        // An unfinished read must still complete on the bus; mark its data stale.
        r_discard <= (r_state == REQ) & ~w_done;
      end else if (w_done) begin
        if (!r_discard) begin
          r_pc <= r_pc + ADDR_WIDTH'(PC_STEP);
        end
        r_discard <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_fetch.sv
// Self-checking bench for wb_fetch: ROM slave model with wait states and error injection,
// expected-entry queue filled by each scenario and drained against the fetch stream.
// Bus activity is logged by a monitor so scenarios can check request addresses and spacing.
module tb_wb_fetch;
  import fetch_pkg::*;

  logic        sys_clk;
  logic        sys_rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_insn;
  logic [31:0] fetch_pc;
  logic        fetch_err;

  int n_tests = 0;
  int n_fail  = 0;

  wb_fetch_if #(.ADDR_WIDTH(32)) wb ();

  wb_fetch #(
    .ADDR_WIDTH (32),
    .RESET_PC   (32'h0000_0000),
    .DEPTH      (2)
  ) dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .wb             (wb),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_valid    (fetch_valid),
    .fetch_ready    (fetch_ready),
    .fetch_insn     (fetch_insn),
    .fetch_pc       (fetch_pc),
    .fetch_err      (fetch_err)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // ---------------- slave model ----------------
  int          slv_wait = 0;
  logic        err_en   = 1'b0;
  logic [31:0] err_adr  = 32'h0;
  int          wcnt;
  logic        w_hit;
  logic        w_is_err;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'h1111_1111 * ((a >> 2) + 32'd1);
  endfunction

  assign w_hit      = wb.wb_cyc && wb.wb_stb && (wcnt >= slv_wait);
  assign w_is_err   = err_en && (wb.wb_adr == err_adr);
  assign wb.wb_ack  = w_hit && !w_is_err;
  assign wb.wb_err  = w_hit && w_is_err;
  assign wb.wb_miso = rom_word(wb.wb_adr);

  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) wcnt <= 0;
    else if (wb.wb_cyc && wb.wb_stb && !(wb.wb_ack || wb.wb_err)) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  // ---------------- bus monitor ----------------
  int          cyc_no = 0;
  logic [31:0] adr_log[$];
  int          ack_cyc[$];
  int          b2b_cnt = 0;
  int          cyc_hi_cnt = 0;
  bit          prev_hit = 0;

  always @(posedge sys_clk) cyc_no <= cyc_no + 1;

  always @(negedge sys_clk) begin
    if (!sys_rst && wb.wb_cyc) cyc_hi_cnt++;
    if (!sys_rst && wb.wb_cyc && wb.wb_stb && (wb.wb_ack || wb.wb_err)) begin
      adr_log.push_back(wb.wb_adr);
      ack_cyc.push_back(cyc_no);
      if (prev_hit) b2b_cnt++;
      prev_hit = 1;
    end else begin
      prev_hit = 0;
    end
  end

  // ---------------- scoreboard ----------------
  fetch_entry_t exp_q[$];
  int           log_base;

  task automatic push_exp(input logic [31:0] a, input logic e);
    fetch_entry_t x;
    x.insn = e ? 32'h0 : rom_word(a);
    x.pc   = a;
    x.err  = e;
    exp_q.push_back(x);
  endtask

  // Accept entries until the expected queue is empty, comparing each against the queue head.
  task automatic drain(input string name, input int budget);
    fetch_entry_t x;
    bit done = 0;
    fetch_ready = 1'b1;
    for (int k = 0; k < budget; k++) begin
      @(negedge sys_clk);
      if (fetch_valid) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL %s: unexpected entry pc=%h insn=%h", name, fetch_pc, fetch_insn);
        end else begin
          x = exp_q.pop_front();
          if ({fetch_insn, fetch_pc, fetch_err} !== {x.insn, x.pc, x.err}) begin
            n_fail++;
            $display("FAIL %s: got insn=%h pc=%h err=%b, want insn=%h pc=%h err=%b",
                     name, fetch_insn, fetch_pc, fetch_err, x.insn, x.pc, x.err);
          end
        end
      end
      @(posedge sys_clk); #1;
      if (exp_q.size() == 0) begin
        done = 1;
        break;
      end
    end
    fetch_ready = 1'b0;
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: timeout, %0d entries never delivered", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    sys_rst        = 1'b1;
    fetch_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    slv_wait       = 0;
    err_en         = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst  = 1'b0;
    log_base = adr_log.size();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    sys_rst        = 1'b1;
    fetch_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    repeat (2) @(posedge sys_clk);
    #1;
    n_tests++; if (wb.wb_cyc !== 1'b0)      begin n_fail++; $display("FAIL rst_cyc: got %b want 0", wb.wb_cyc); end
    n_tests++; if (wb.wb_stb !== 1'b0)      begin n_fail++; $display("FAIL rst_stb: got %b want 0", wb.wb_stb); end
    n_tests++; if (wb.wb_we !== 1'b0)       begin n_fail++; $display("FAIL rst_we: got %b want 0", wb.wb_we); end
    n_tests++; if (wb.wb_adr !== 32'h0)     begin n_fail++; $display("FAIL rst_adr: got %h want 0", wb.wb_adr); end
    n_tests++; if (wb.wb_mosi !== 32'h0)    begin n_fail++; $display("FAIL rst_mosi: got %h want 0", wb.wb_mosi); end
    n_tests++; if (wb.wb_sel !== 4'hF)      begin n_fail++; $display("FAIL rst_sel: got %h want f", wb.wb_sel); end
    n_tests++; if (fetch_valid !== 1'b0)    begin n_fail++; $display("FAIL rst_valid: got %b want 0", fetch_valid); end
  endtask

  task automatic test_sequential();
    logic [31:0] want;
    int b2b0;
    do_reset();
    b2b0 = b2b_cnt;
    push_exp(32'h0, 1'b0);
    push_exp(32'h4, 1'b0);
    push_exp(32'h8, 1'b0);
    drain("seq", 200);
    for (int i = 0; i < 3; i++) begin
      want = 32'(i * 4);
      n_tests++;
      if (adr_log.size() <= log_base + i || adr_log[log_base + i] !== want) begin
        n_fail++;
        $display("FAIL seq_adr%0d: got %h want %h", i,
                 (adr_log.size() > log_base + i) ? adr_log[log_base + i] : 32'hx, want);
      end
    end
    n_tests++;
    if (b2b_cnt != b2b0) begin n_fail++; $display("FAIL seq_stb_gap: %0d back-to-back acks, want 0", b2b_cnt - b2b0); end
    n_tests++;
    if (ack_cyc.size() < log_base + 2 || ack_cyc[log_base + 1] - ack_cyc[log_base] != 3) begin
      n_fail++;
      $display("FAIL seq_rate: ack spacing %0d want 3",
               (ack_cyc.size() >= log_base + 2) ? ack_cyc[log_base + 1] - ack_cyc[log_base] : -1);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    repeat (20) @(posedge sys_clk);
    #1;
    n_tests++;
    if (adr_log.size() - log_base != 2) begin n_fail++; $display("FAIL bp_count: got %0d transfers want 2", adr_log.size() - log_base); end
    n_tests++;
    if (wb.wb_cyc !== 1'b0) begin n_fail++; $display("FAIL bp_cyc: got %b want 0", wb.wb_cyc); end
    push_exp(32'h0, 1'b0);
    push_exp(32'h4, 1'b0);
    push_exp(32'h8, 1'b0);
    drain("bp", 200);
    n_tests++;
    if (adr_log.size() <= log_base + 2 || adr_log[log_base + 2] !== 32'h8) begin
      n_fail++; $display("FAIL bp_resume: third request not at 00000008");
    end
  endtask

  task automatic test_redirect_mid_req();
    bit seen = 0;
    do_reset();
    slv_wait = 3;
    push_exp(32'h0, 1'b0);
    push_exp(32'h4, 1'b0);
    drain("redir_pre", 200);
    for (int k = 0; k < 50; k++) begin
      if (wb.wb_stb && wb.wb_adr == 32'h8 && !wb.wb_ack) begin
        seen = 1;
        break;
      end
      @(posedge sys_clk); #1;
    end
    n_tests++;
    if (!seen) begin n_fail++; $display("FAIL redir_wait: no pending request at 00000008"); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    @(posedge sys_clk); #1;
    redirect_valid = 1'b0;
    push_exp(32'h100, 1'b0);
    push_exp(32'h104, 1'b0);
    drain("redir_post", 300);
    n_tests++;
    if (adr_log.size() <= log_base + 3 || adr_log[log_base + 2] !== 32'h8 || adr_log[log_base + 3] !== 32'h100) begin
      n_fail++; $display("FAIL redir_adr: requests after redirect not 00000008 then 00000100");
    end
  endtask

  task automatic test_redirect_full();
    do_reset();
    repeat (20) @(posedge sys_clk);
    #1;
    n_tests++;
    if (fetch_valid !== 1'b1) begin n_fail++; $display("FAIL rfull_pre: valid=%b want 1", fetch_valid); end
    fetch_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    @(posedge sys_clk); #1;
    fetch_ready    = 1'b0;
    redirect_valid = 1'b0;
    n_tests++;
    if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL rfull_flush: valid=%b want 0", fetch_valid); end
    push_exp(32'h40, 1'b0);
    drain("rfull_post", 200);
  endtask

  task automatic test_bus_error();
    int hi0;
    do_reset();
    err_en  = 1'b1;
    err_adr = 32'h10;
    push_exp(32'h0, 1'b0);
    push_exp(32'h4, 1'b0);
    push_exp(32'h8, 1'b0);
    push_exp(32'hC, 1'b0);
    push_exp(32'h10, 1'b1);
`ifdef FETCH_ERR_HALT_EN
    drain("berr", 300);
    hi0 = cyc_hi_cnt;
    repeat (20) @(posedge sys_clk);
    #1;
    n_tests++;
    if (cyc_hi_cnt != hi0) begin n_fail++; $display("FAIL berr_halt: cyc high %0d cycles want 0", cyc_hi_cnt - hi0); end
    err_en         = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    @(posedge sys_clk); #1;
    redirect_valid = 1'b0;
    push_exp(32'h0, 1'b0);
    drain("berr_restart", 200);
`else
    hi0 = 0;
    push_exp(32'h14, 1'b0);
    drain("berr", 300);
    n_tests++;
    if (adr_log.size() <= log_base + 5 || adr_log[log_base + 5] !== 32'h14) begin
      n_fail++; $display("FAIL berr_next: request after error not 00000014 (hi0=%0d)", hi0);
    end
`endif
    err_en = 1'b0;
  endtask

  task automatic test_async_reset();
    bit seen = 0;
    do_reset();
    slv_wait = 5;
    for (int k = 0; k < 60; k++) begin
      if (wb.wb_stb && wb.wb_adr == 32'h4) begin
        seen = 1;
        break;
      end
      @(posedge sys_clk); #1;
    end
    n_tests++;
    if (!seen || fetch_valid !== 1'b1) begin n_fail++; $display("FAIL arst_setup: seen=%b valid=%b want 1 1", seen, fetch_valid); end
    #2;
    sys_rst = 1'b1;
    #1;
    n_tests++;
    if (wb.wb_cyc !== 1'b0 || wb.wb_stb !== 1'b0) begin n_fail++; $display("FAIL arst_bus: cyc=%b stb=%b want 0 0", wb.wb_cyc, wb.wb_stb); end
    n_tests++;
    if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %b want 0", fetch_valid); end
    @(posedge sys_clk); #1;
    slv_wait = 0;
    sys_rst  = 1'b0;
    log_base = adr_log.size();
    push_exp(32'h0, 1'b0);
    drain("arst_post", 200);
    n_tests++;
    if (adr_log.size() <= log_base || adr_log[log_base] !== 32'h0) begin
      n_fail++; $display("FAIL arst_pc: first request after reset not at 00000000");
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_mid_req();
    test_redirect_full();
    test_bus_error();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
